// File: rtl/call_stack_pkg.sv
// Shared defines for the call stack and the jump controller: default sizes,
// the {push,pop} operation encoding and the jump opcodes. Optional feature macro: CALL_STACK_ERR_EN.
package call_stack_pkg;

  localparam int CS_DEPTH      = 8;
  localparam int CS_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_PUSHPOP = 2'b11
  } stack_op_e;

  localparam logic [3:0] OPC_JMP = 4'hB;
  localparam logic [3:0] OPC_JSB = 4'hC;
  localparam logic [3:0] OPC_RET = 4'hD;

endpackage

// File: rtl/call_stack.sv
// Return-address stack for JSB/RET with combinational top-of-stack output.
// Define CALL_STACK_ERR_EN to add sticky overflow/underflow flags and err_clr.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int DEPTH      = CS_DEPTH,
  parameter int ADDR_WIDTH = CS_ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_stack,
  input  logic                         pop_stack,
  input  logic                         stall,
  input  logic [ADDR_WIDTH-1:0]        push_addr,
`ifdef CALL_STACK_ERR_EN
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow,
`endif
  output logic [ADDR_WIDTH-1:0]        top_addr,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]         sp_q, sp_d;
  logic [IW-1:0]         top_idx_s;
  logic [IW-1:0]         wr_idx_s;
  logic                  wr_en_s;
  logic                  empty_s, full_s;
  stack_op_e             op_s;

  assign op_s      = stack_op_e'({push_stack, pop_stack});
  assign empty_s   = (sp_q == {CW{1'b0}});
  assign full_s    = (sp_q == CW'(DEPTH));
  assign top_idx_s = IW'(sp_q - CW'(1));

  assign top_addr = empty_s ? {ADDR_WIDTH{1'b0}} : mem_q[top_idx_s];
  assign count    = sp_q;
  assign empty    = empty_s;
  assign full     = full_s;

  // Next stack pointer and write port; push+pop on a non-empty stack replaces the top in place
  always_comb begin
    sp_d     = sp_q;
    wr_en_s  = 1'b0;
    wr_idx_s = IW'(sp_q);
    if (!stall) begin
      case (op_s)
        OP_PUSH: begin
          if (!full_s) begin
            wr_en_s = 1'b1;
            sp_d    = sp_q + CW'(1);
          end else begin
            sp_d = sp_q;
          end
        end
        OP_POP: begin
          if (!empty_s) begin
            sp_d = sp_q - CW'(1);
          end else begin
            sp_d = sp_q;
          end
        end
        OP_PUSHPOP: begin
          wr_en_s = 1'b1;
          if (empty_s) begin
            sp_d = CW'(1);
          end else begin
            wr_idx_s = top_idx_s;
          end
        end
        default: begin
          sp_d = sp_q;
        end
      endcase
    end else begin
      sp_d = sp_q;
    end
  end

  // Stack pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= {CW{1'b0}};
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage; contents need no reset since sp gates visibility
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= push_addr;
    end
  end

`ifdef CALL_STACK_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic ovf_ev_s, unf_ev_s;

  assign ovf_ev_s = !stall && (op_s == OP_PUSH) && full_s;
  assign unf_ev_s = !stall && ((op_s == OP_POP) || (op_s == OP_PUSHPOP)) && empty_s;

  // Sticky error flags; a same-cycle event wins over err_clr
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!stall) begin
      ovf_d = (ovf_q & ~err_clr) | ovf_ev_s;
      unf_d = (unf_q & ~err_clr) | unf_ev_s;
    end else begin
      ovf_d = ovf_q;
      unf_d = unf_q;
    end
  end

  // Error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_call_stack.sv
// Self-checking bench for call_stack: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_call_stack;
  localparam int DEPTH = 8;
  localparam int AW    = 12;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_stack = 1'b0, pop_stack = 1'b0, stall = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic [AW-1:0] top_addr;
  logic [CW-1:0] count;
  logic          empty, full;
  logic          err_clr_v = 1'b0;
  logic          overflow_v, underflow_v;

`ifdef CALL_STACK_ERR_EN
  logic overflow, underflow, err_clr;
  assign err_clr     = err_clr_v;
  assign overflow_v  = overflow;
  assign underflow_v = underflow;
`else
  assign overflow_v  = 1'b0;
  assign underflow_v = 1'b0;
`endif

  call_stack #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .push_stack(push_stack), .pop_stack(pop_stack),
    .stall(stall), .push_addr(push_addr),
`ifdef CALL_STACK_ERR_EN
    .err_clr(err_clr), .overflow(overflow), .underflow(underflow),
`endif
    .top_addr(top_addr), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: a queue holding the live entries, bottom first
  int unsigned stk[$];
  bit m_ovf = 1'b0, m_unf = 1'b0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned m_top();
    return (stk.size() == 0) ? 0 : stk[stk.size()-1];
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"}, count, stk.size());
    chk({tag, ".top"}, top_addr, m_top());
    chk({tag, ".empty"}, empty, stk.size() == 0);
    chk({tag, ".full"}, full, stk.size() == DEPTH);
`ifdef CALL_STACK_ERR_EN
    chk({tag, ".ovf"}, overflow_v, m_ovf);
    chk({tag, ".unf"}, underflow_v, m_unf);
`endif
  endtask

  task automatic model(input bit p, input bit q, input bit s, input int unsigned a, input bit clr);
    bit ov, un;
    ov = 1'b0; un = 1'b0;
    if (!s) begin
      if (p && q) begin
        if (stk.size() == 0) begin stk.push_back(a); un = 1'b1; end
        else stk[stk.size()-1] = a;
      end else if (p) begin
        if (stk.size() == DEPTH) ov = 1'b1;
        else stk.push_back(a);
      end else if (q) begin
        if (stk.size() == 0) un = 1'b1;
        else void'(stk.pop_back());
      end
      m_ovf = (m_ovf & ~clr) | ov;
      m_unf = (m_unf & ~clr) | un;
    end
  endtask

  // apply one cycle of stimulus, advance the model, then compare
  task automatic op(input string tag, input bit p, input bit q, input bit s,
                    input int unsigned a, input bit clr = 1'b0);
    push_stack = p; pop_stack = q; stall = s; push_addr = AW'(a);
`ifdef CALL_STACK_ERR_EN
    err_clr_v = clr;
`else
    err_clr_v = 1'b0;
`endif
    @(posedge clk);
    #1;
    model(p, q, s, a, err_clr_v);
    push_stack = 1'b0; pop_stack = 1'b0; stall = 1'b0; err_clr_v = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    stk.delete();
    check_state("por");
    chk("por.top0", top_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic push/pop
    op("p10", 1, 0, 0, 'h010);
    op("p20", 1, 0, 0, 'h020);
    op("p30", 1, 0, 0, 'h030);
    chk("req27.top", top_addr, 'h030);
    chk("req27.cnt", count, 3);
    op("pop", 0, 1, 0, 0);
    chk("req27.top2", top_addr, 'h020);
    chk("req27.cnt2", count, 2);
    do_reset();

    // fill, overflow, drain
    for (int i = 1; i <= DEPTH; i++) op("fill", 1, 0, 0, i);
    op("ovf", 1, 0, 0, 'h0FF);
    chk("req28.full", full, 1);
    chk("req28.top", top_addr, DEPTH);
    for (int i = 0; i < DEPTH; i++) op("drain", 0, 1, 0, 0);
    chk("req28.empty", empty, 1);
    chk("req28.top0", top_addr, 0);

    // underflow and clear
    op("unf", 0, 1, 0, 0);
    chk("req29.cnt", count, 0);
    op("clr", 0, 0, 0, 0, 1'b1);
    op("pp_empty", 1, 1, 0, 'h0AB);
    chk("pp_empty.cnt", count, 1);
    do_reset();

    // push+pop replace, including when full
    op("p100", 1, 0, 0, 'h100);
    op("pp200", 1, 1, 0, 'h200);
    chk("req30.cnt", count, 1);
    chk("req30.top", top_addr, 'h200);
    for (int i = 1; i < DEPTH; i++) op("fill2", 1, 0, 0, 'h300 + i);
    op("ppfull", 1, 1, 0, 'h3AA);
    chk("req30.full_cnt", count, DEPTH);
    chk("req30.full_top", top_addr, 'h3AA);
    do_reset();

    // stall freezes state
    op("stall", 1, 0, 1, 'h055);
    chk("req31.cnt0", count, 0);
    op("nostall", 1, 0, 0, 'h055);
    chk("req31.cnt1", count, 1);
    chk("req31.top", top_addr, 'h055);

    // async reset mid-cycle
    op("r1", 1, 0, 0, 'h011);
    op("r2", 1, 0, 0, 'h022);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("req32.cnt", count, 0);
    chk("req32.top", top_addr, 0);
    chk("req32.empty", empty, 1);
    stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_state("req32");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit p, q, s, c;
      p = ($urandom_range(0, 99) < 50);
      q = ($urandom_range(0, 99) < 40);
      s = ($urandom_range(0, 99) < 15);
      c = ($urandom_range(0, 99) < 5);
      op("rand", p, q, s, $urandom_range(0, (1 << AW) - 1), c);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
